firebird7_in_gate1_tessent_tdr_w3_ctrl: RTL and testbench

IJTAG test data register (TDR) that drives the select and data inputs of the 3-bit IJTAG/functional data mux in firebird7_in_gate1. It holds a shift chain and an update register of DATA_WIDTH+1 bits. The update register drives `ijtag_select` and `ijtag_data_in`, which feed the mux directly. Capture loads the mux's functional-side data so the scan path can observe it.

---
 rtl/firebird7_in_gate1_tessent_tdr_w3_ctrl.sv | 105 ++++++++++
 tb/tb_firebird7_in_gate1_tessent_tdr_w3_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/firebird7_in_gate1_tessent_tdr_w3_ctrl.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_tessent_tdr_w3_ctrl
//
// IJTAG test data register that drives the select and data inputs of the
// 3-bit IJTAG/functional data mux in firebird7_in_gate1. A DATA_WIDTH+1 bit
// shift chain feeds an update register of the same width. The update register
// drives the mux directly. Capture loads the chain so the scan path can
// observe the mux inputs.
//
// Chain layout: shift_reg[DATA_WIDTH] = select field,
//               shift_reg[DATA_WIDTH-1:0] = data field, LSB shifts out first.
//
// Optional build macro: FIREBIRD7_IN_GATE1_TDR_CAPTURE_EN
//   defined   : capture loads {current select, functional_data_in}
//   undefined : capture reloads the update register (plain readback);
//               functional_data_in is then unused
//
// Ports
//   ijtag_tck           in   IJTAG clock (all state on rising edge, except so)
//   ijtag_reset         in   asynchronous active-low reset
//   ijtag_sel           in   TDR selected on the active scan path
//   ijtag_ce            in   capture enable
//   ijtag_se            in   shift enable
//   ijtag_ue            in   update enable
//   ijtag_si            in   scan in
//   ijtag_so            out  scan out, retimed on the falling edge
//   functional_data_in  in   functional-side mux data, capture source
//   ijtag_select        out  mux select (update register MSB)
//   ijtag_data_in       out  mux IJTAG data (update register data field)
// -----------------------------------------------------------------------------
module firebird7_in_gate1_tessent_tdr_w3_ctrl #(
   parameter int DATA_WIDTH = 3
) (
   input  logic                  ijtag_tck,
   input  logic                  ijtag_reset,
   input  logic                  ijtag_sel,
   input  logic                  ijtag_ce,
   input  logic                  ijtag_se,
   input  logic                  ijtag_ue,
   input  logic                  ijtag_si,
   output logic                  ijtag_so,
   input  logic [DATA_WIDTH-1:0] functional_data_in,
   output logic                  ijtag_select,
   output logic [DATA_WIDTH-1:0] ijtag_data_in
);

   logic [DATA_WIDTH:0] shift_reg;
   logic [DATA_WIDTH:0] upd_reg;
   logic [DATA_WIDTH:0] capture_val;
   logic                so_q;

`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_EN
   // The current select is read back alongside the functional data so the
   // scan path can tell which side of the mux is live.
   always_comb begin
      capture_val = {upd_reg[DATA_WIDTH], functional_data_in};
   end
`else
   logic fdi_unused;

   assign fdi_unused = ^functional_data_in;

   always_comb begin
      capture_val = upd_reg;
   end
`endif

   // Capture wins over shift; ce and se together is a controller error and
   // resolves to capture.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         shift_reg <= '0;
      end else if (ijtag_sel) begin
         if (ijtag_ce) begin
            shift_reg <= capture_val;
         end else if (ijtag_se) begin
            shift_reg <= {ijtag_si, shift_reg[DATA_WIDTH:1]};
         end
      end
   end

   // Update is independent of ce/se and always sees the pre-edge chain.
   always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         upd_reg <= '0;
      end else if (ijtag_sel && ijtag_ue) begin
         upd_reg <= shift_reg;
      end
   end

   // Falling-edge retime keeps scan out stable across the next rising edge
   // of the downstream TDR.
   always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
      if (!ijtag_reset) begin
         so_q <= 1'b0;
      end else begin
         so_q <= shift_reg[0];
      end
   end

   assign ijtag_so      = so_q;
   assign ijtag_select  = upd_reg[DATA_WIDTH];
   assign ijtag_data_in = upd_reg[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w3_ctrl.sv
module tb_firebird7_in_gate1_tessent_tdr_w3_ctrl;

   logic       tck;
   logic       rst_n;
   logic       sel_i, ce_i, se_i, ue_i, si_i;
   logic [2:0] fdi_i;
   logic       so_o;
   logic       select_o;
   logic [2:0] data_o;

   int n_cmp = 0;
   int n_bad = 0;
   int n_illegal = 0;

   // reference model: chain and update register as plain integers
   int m_chain = 0;
   int m_upd   = 0;

   logic       p_sel;
   logic [2:0] p_data;
   logic       p_so;

   firebird7_in_gate1_tessent_tdr_w3_ctrl #(.DATA_WIDTH(3)) dut (
      .ijtag_tck          (tck),
      .ijtag_reset        (rst_n),
      .ijtag_sel          (sel_i),
      .ijtag_ce           (ce_i),
      .ijtag_se           (se_i),
      .ijtag_ue           (ue_i),
      .ijtag_si           (si_i),
      .ijtag_so           (so_o),
      .functional_data_in (fdi_i),
      .ijtag_select       (select_o),
      .ijtag_data_in      (data_o)
   );

   initial begin
      tck = 1'b0;
      forever #5 tck = ~tck;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // model: rules applied to the whole register value at once
   always @(posedge tck or negedge rst_n) begin
      if (!rst_n) begin
         m_chain = 0;
         m_upd   = 0;
      end else if (sel_i) begin
         int old_chain;
         old_chain = m_chain;
         if (ce_i && se_i) n_illegal++;
         if (ce_i) begin
`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_EN
            m_chain = (m_upd & 8) + int'(fdi_i);
`else
            m_chain = m_upd;
`endif
         end else if (se_i) begin
            m_chain = (int'(si_i) * 8) + (m_chain / 2);
         end
         if (ue_i) m_upd = old_chain;
      end
   end

   // every cycle: outputs against the model, half a cycle after the rising edge
   always @(negedge tck) begin
      #1;
      chk("model_select", select_o, (m_upd / 8) % 2);
      chk("model_data", data_o, m_upd % 8);
      chk("model_so", so_o, m_chain % 2);
   end

   // one clock: inputs applied between edges, results latched after each edge
   task automatic step(input logic sel, input logic ce, input logic se,
                       input logic ue, input logic si, input logic [2:0] fdi);
      sel_i = sel; ce_i = ce; se_i = se; ue_i = ue; si_i = si; fdi_i = fdi;
      @(posedge tck);
      #1;
      p_sel  = select_o;
      p_data = data_o;
      @(negedge tck);
      #1;
      p_so = so_o;
      #1;
   endtask

   task automatic shift_bit(input logic b);
      step(1'b1, 1'b0, 1'b1, 1'b0, b, 3'b000);
   endtask

   task automatic update_now();
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000);
   endtask

   // value v[3:0] ends up in the chain: v[0] shifted first
   task automatic load(input logic [3:0] v);
      for (int i = 0; i < 4; i++) shift_bit(v[i]);
   endtask

   task automatic reset_pulse(input logic check_zero);
      rst_n = 1'b0;
      #1;
      if (check_zero) begin
         chk("rst_select", select_o, 0);
         chk("rst_data", data_o, 0);
         chk("rst_so", so_o, 0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      logic [3:0] exp_so;
      rst_n = 1'b0;
      sel_i = 0; ce_i = 0; se_i = 0; ue_i = 0; si_i = 0; fdi_i = 3'b000;
      @(negedge tck);
      #2;
      chk("reset_select", select_o, 0);
      chk("reset_data", data_o, 0);
      chk("reset_so", so_o, 0);
      rst_n = 1'b1;

      // load 1,0,1,1 then update
      shift_bit(1); shift_bit(0); shift_bit(1); shift_bit(1);
      chk("load_before_sel", p_sel, 0);
      chk("load_before_data", p_data, 0);
      update_now();
      chk("load_sel", p_sel, 1);
      chk("load_data", p_data, 3'b101);

      // async reset mid-cycle with outputs non-zero
      reset_pulse(1'b1);

      // capture and shift out
      load(4'b1010);
      update_now();
      chk("cap_setup_sel", p_sel, 1);
      chk("cap_setup_data", p_data, 3'b010);
`ifdef FIREBIRD7_IN_GATE1_TDR_CAPTURE_EN
      exp_so = 4'b1110;
`else
      exp_so = 4'b1010;
`endif
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110);
      chk("cap_so0", p_so, exp_so[0]);
      for (int i = 1; i < 4; i++) begin
         shift_bit(0);
         chk($sformatf("cap_so%0d", i), p_so, exp_so[i]);
      end

      // deselected hold
      load(4'b0110);
      update_now();
      load(4'b1101);
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111);
         chk("hold_sel", p_sel, 0);
         chk("hold_data", p_data, 3'b110);
         chk("hold_so", p_so, 1);
      end
      update_now();
      chk("hold_upd_sel", p_sel, 1);
      chk("hold_upd_data", p_data, 3'b101);

      // simultaneous se and ue
      load(4'b0111);
      step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b000);
      chk("seue_sel", p_sel, 0);
      chk("seue_data", p_data, 3'b111);
      update_now();
      chk("seue_chain_sel", p_sel, 1);
      chk("seue_chain_data", p_data, 3'b011);

      // reset during shift
      shift_bit(1); shift_bit(1);
      reset_pulse(1'b0);
      load(4'b1001);
      update_now();
      chk("rstshift_sel", p_sel, 1);
      chk("rstshift_data", p_data, 3'b001);

      // randomized traffic, checked every cycle by the model compare
      for (int n = 0; n < 600; n++) begin
         logic sel, ce, se, ue;
         sel = ($urandom_range(0, 9) != 0);
         ce  = ($urandom_range(0, 7) == 0);
         se  = ($urandom_range(0, 3) != 0);
         ue  = ($urandom_range(0, 5) == 0);
         if (ce && se && $urandom_range(0, 3) != 0) se = 1'b0;
         step(sel, ce, se, ue, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
         if ($urandom_range(0, 79) == 0) reset_pulse(1'b1);
      end

      @(negedge tck);
      #3;
      if (n_illegal > 0) $display("note: %0d edges drove ce and se together (illegal controller state)", n_illegal);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
